pitch_calib_ctrl: RTL and testbench
===================================

Name: pitch_calib_ctrl

Overview:
Closed-loop calibration sequencer for the theremin pitch generation path. It measures the antenna oscillator square wave (square_freq) over a fixed gate window, compares the edge count with a software-supplied target and issues one-cycle up/down step commands on freq_up_down until the count is within tolerance. It also drives the cal_glis mode code. It sits between the Avalon control registers (start/abort/target/tolerance) and the pitch generation conduit inputs.

Parameters:
CNT_W, 16, width of edge counter, target, tolerance and meas_cnt
GATE_CYCLES, 50000, clk cycles per measurement window (>=2)
SETTLE_CYCLES, 5000, clk cycles waited after each step before remeasuring (>=1)
MAX_ITER, 64, maximum step commands before declaring failure (>=1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin calibration; ignored while busy
abort  in  1  one-cycle request to abandon calibration; returns to IDLE
square_freq  in  1  asynchronous antenna oscillator square wave
target_cnt  in  CNT_W  required rising-edge count per gate window; sampled on accepted start
tol  in  CNT_W  allowed |meas-target|; sampled on accepted start
freq_up_down  out  2  step command: 01 up, 10 down, 00 hold; never 11
cal_glis  out  2  mode: 00 idle, 01 calibrating, 10 locked, 11 failed
busy  out  1  high in any state other than IDLE/LOCKED/FAILED
done  out  1  one-cycle pulse on entry to LOCKED
fail  out  1  one-cycle pulse on entry to FAILED
meas_cnt  out  CNT_W  last completed window count; held between windows

Behaviour:
- Reset (async, any state): state IDLE, freq_up_down=00, cal_glis=00, busy=0, done=0, fail=0, meas_cnt=0, all counters 0.
- square_freq: 2-flop synchronizer plus one history flop; a rising edge is counted when sync=1 and history=0. Edge counter saturates at all-ones and never wraps.
- States: IDLE, MEASURE, COMPARE, STEP, SETTLE, LOCKED, FAILED.
- IDLE/LOCKED/FAILED + start: latch target_cnt and tol, clear iteration counter, clear edge and gate counters, go to MEASURE. cal_glis=01 and busy=1 from the next cycle.
- MEASURE: runs for exactly GATE_CYCLES cycles; edges are counted only in this state. On the last cycle, meas_cnt is loaded with the final count, including an edge detected in that cycle. Next state is COMPARE.
- COMPARE (1 cycle): compute diff = meas-target in CNT_W+1 signed arithmetic.
  - |diff| <= tol: go to LOCKED, pulse done, cal_glis=10.
  - Else, if the iteration counter already equals MAX_ITER: go to FAILED, pulse fail, cal_glis=11.
  - Else: go to STEP.
- STEP (1 cycle): freq_up_down=01 if meas<target, 10 if meas>target. Increment the iteration counter, then go to SETTLE. freq_up_down is 00 in every other state.
- SETTLE: hold for SETTLE_CYCLES cycles, then clear the edge counter and go to MEASURE.
- LOCKED/FAILED: hold, busy=0, meas_cnt retained. cal_glis stays 10 or 11 until start or abort.
- abort (any state): next state IDLE, cal_glis=00, freq_up_down=00, no done/fail pulse. abort has priority over start in the same cycle. meas_cnt is retained.
- start while busy: ignored, latched target and tol unchanged.
- tol >= all-ones: the first COMPARE always locks.
- Latency:
  - Accepted start to first COMPARE = GATE_CYCLES+1 cycles.
  - Each further iteration = 1 (STEP) + SETTLE_CYCLES + GATE_CYCLES + 1 (COMPARE).
  - done asserts the cycle after COMPARE.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- pitch_calib_pkg: state enum, freq_up_down codes (UD_HOLD, UD_UP, UD_DOWN), cal_glis codes (CG_IDLE, CG_CAL, CG_LOCK, CG_FAIL).
- One sub-module: edge_sync_counter. Contains the synchronizer, rising-edge detect and a saturating counter with clear/enable.
- FSM, gate/settle timer and comparator live in the top.

Test Plan:
- Common bench setup: GATE_CYCLES=1000, SETTLE_CYCLES=10, MAX_ITER=4, CNT_W=16.
- square_freq = clk/10, target 100, tol 2, start -> meas_cnt=100, done pulse at cycle 1001 after start, cal_glis=10, freq_up_down never nonzero.
- Bench oscillator model: count +5 per 01 step. Start at 90, target 100, tol 1 -> two 01 pulses, then done, meas_cnt=100, 3 COMPAREs total.
- Oscillator fixed at 200, target 100, tol 0 -> four 10 pulses, then fail pulse, cal_glis=11, busy=0.
- abort asserted mid-SETTLE of iteration 2 -> IDLE next cycle, cal_glis=00, no done/fail. A new start then re-latches target and runs from MEASURE.
- reset_n low mid-MEASURE -> all outputs 0 immediately (async). After release, start with target 0, tol 65535 and square_freq held low -> meas_cnt=0 and locks on the first COMPARE.
- start and abort in the same cycle from IDLE -> stays IDLE. start pulse while busy -> latched target unchanged, iteration count unaffected.

Source files
------------

// File: rtl/pitch_calib_pkg.sv
// ============================================================================
// Module : pitch_calib_pkg
// Brief  : Shared state encoding and output codes for the pitch calibrator.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package pitch_calib_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MEASURE = 3'd1,
        ST_COMPARE = 3'd2,
        ST_STEP    = 3'd3,
        ST_SETTLE  = 3'd4,
        ST_LOCKED  = 3'd5,
        ST_FAILED  = 3'd6
    } state_t;

    localparam logic [1:0] UD_HOLD = 2'b00;
    localparam logic [1:0] UD_UP   = 2'b01;
    localparam logic [1:0] UD_DOWN = 2'b10;

    localparam logic [1:0] CG_IDLE = 2'b00;
    localparam logic [1:0] CG_CAL  = 2'b01;
    localparam logic [1:0] CG_LOCK = 2'b10;
    localparam logic [1:0] CG_FAIL = 2'b11;

endpackage

`default_nettype wire

// File: rtl/pitch_calib_ctrl_if.sv
// ============================================================================
// Module : pitch_calib_ctrl_if
// Brief  : Control/status bundle between the register block and calibrator.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface pitch_calib_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] target_cnt;
    logic [CNT_W-1:0] tol;
    logic             busy;
    logic             done;
    logic             fail;
    logic [CNT_W-1:0] meas_cnt;

    modport master (
        output start, abort, target_cnt, tol,
        input  busy, done, fail, meas_cnt
    );

    modport slave (
        input  start, abort, target_cnt, tol,
        output busy, done, fail, meas_cnt
    );
endinterface

`default_nettype wire

// File: rtl/pitch_calib_ctrl_edge_sync_counter.sv
// ============================================================================
// Module : edge_sync_counter
// Brief  : Synchronises an async square wave and counts its rising edges.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module edge_sync_counter #(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             sig_async,
    input  wire logic             clr,
    input  wire logic             en,
    output logic      [CNT_W-1:0] count_next
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_hist;
    logic [CNT_W-1:0] r_cnt;
    logic             w_edge;
    logic             w_sat;

    assign w_edge = r_sync2 & ~r_hist;
    assign w_sat  = &r_cnt;

    // Exposed so the owner can capture a count that includes this cycle's edge.
    assign count_next = (en && w_edge && !w_sat) ? r_cnt + CNT_W'(1) : r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= sig_async;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            r_cnt   <= clr ? '0 : count_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pitch_calib_ctrl.sv
// ============================================================================
// Module : pitch_calib_ctrl
// Brief  : Closed-loop oscillator calibration: measure, compare, step, settle.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pitch_calib_ctrl #(
    parameter int CNT_W         = 16,
    parameter int GATE_CYCLES   = 50000,
    parameter int SETTLE_CYCLES = 5000,
    parameter int MAX_ITER      = 64
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    pitch_calib_ctrl_if.slave ctl,
    input  wire logic       square_freq,
    output logic      [1:0] freq_up_down,
    output logic      [1:0] cal_glis
);
    import pitch_calib_pkg::*;

    localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int ITER_W  = $clog2(MAX_ITER + 1);

    localparam logic [TMR_W-1:0]  GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [ITER_W-1:0] ITER_LIMIT  = ITER_W'(MAX_ITER);

    state_t            r_state;
    logic [TMR_W-1:0]  r_timer;
    logic [ITER_W-1:0] r_iter;
    logic [CNT_W-1:0]  r_target;
    logic [CNT_W-1:0]  r_tol;
    logic [CNT_W-1:0]  r_meas;
    logic [1:0]        r_ud;
    logic [1:0]        r_cg;
    logic              r_busy;
    logic              r_done;
    logic              r_fail;

    logic              w_start_ok;
    logic              w_cnt_clr;
    logic              w_cnt_en;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [CNT_W:0]    w_diff;
    logic [CNT_W:0]    w_abs;
    logic              w_within;
    logic              w_meas_low;

    assign w_start_ok = ctl.start && !ctl.abort &&
                        ((r_state == ST_IDLE) || (r_state == ST_LOCKED) || (r_state == ST_FAILED));
    assign w_cnt_clr  = w_start_ok ||
                        (!ctl.abort && (r_state == ST_SETTLE) && (r_timer == SETTLE_LAST));
    assign w_cnt_en   = (r_state == ST_MEASURE);

    edge_sync_counter #(
        .CNT_W (CNT_W)
    ) u_edge_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .sig_async  (square_freq),
        .clr        (w_cnt_clr),
        .en         (w_cnt_en),
        .count_next (w_cnt_next)
    );

    // One extra bit keeps the difference signed without overflow.
    assign w_diff     = {1'b0, r_meas} - {1'b0, r_target};
    assign w_meas_low = w_diff[CNT_W];
    assign w_abs      = w_meas_low ? (~w_diff + (CNT_W+1)'(1)) : w_diff;
    assign w_within   = (w_abs <= {1'b0, r_tol});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_timer  <= '0;
            r_iter   <= '0;
            r_target <= '0;
            r_tol    <= '0;
            r_meas   <= '0;
            r_ud     <= UD_HOLD;
            r_cg     <= CG_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_fail   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_fail <= 1'b0;
            if (ctl.abort) begin
                r_state <= ST_IDLE;
                r_ud    <= UD_HOLD;
                r_cg    <= CG_IDLE;
                r_busy  <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_IDLE, ST_LOCKED, ST_FAILED: begin
                        if (w_start_ok) begin
                            r_target <= ctl.target_cnt;
                            r_tol    <= ctl.tol;
                            r_iter   <= '0;
                            r_timer  <= '0;
                            r_state  <= ST_MEASURE;
                            r_cg     <= CG_CAL;
                            r_busy   <= 1'b1;
                        end
                    end
                    ST_MEASURE: begin
                        if (r_timer == GATE_LAST) begin
                            r_meas  <= w_cnt_next;
                            r_timer <= '0;
                            r_state <= ST_COMPARE;
                        end else begin
                            r_timer <= r_timer + TMR_W'(1);
                        end
                    end
                    ST_COMPARE: begin
                        if (w_within) begin
                            r_state <= ST_LOCKED;
                            r_done  <= 1'b1;
                            r_cg    <= CG_LOCK;
                            r_busy  <= 1'b0;
                        end else if (r_iter == ITER_LIMIT) begin
                            r_state <= ST_FAILED;
                            r_fail  <= 1'b1;
                            r_cg    <= CG_FAIL;
                            r_busy  <= 1'b0;
                        end else begin
                            // Registered here so the command is visible exactly during STEP.
                            r_state <= ST_STEP;
                            r_ud    <= w_meas_low ? UD_UP : UD_DOWN;
                        end
                    end
                    ST_STEP: begin
                        r_ud    <= UD_HOLD;
                        r_iter  <= r_iter + ITER_W'(1);
                        r_timer <= '0;
                        r_state <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (r_timer == SETTLE_LAST) begin
                            r_timer <= '0;
                            r_state <= ST_MEASURE;
                        end else begin
                            r_timer <= r_timer + TMR_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_ud    <= UD_HOLD;
                        r_cg    <= CG_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign freq_up_down = r_ud;
    assign cal_glis     = r_cg;
    assign ctl.busy     = r_busy;
    assign ctl.done     = r_done;
    assign ctl.fail     = r_fail;
    assign ctl.meas_cnt = r_meas;

endmodule

`default_nettype wire

// File: tb/tb_pitch_calib_ctrl.sv
// ============================================================================
// Module : tb_pitch_calib_ctrl
// Brief  : Scoreboard bench with a steppable oscillator model for the calibrator.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pitch_calib_ctrl;

    localparam int G      = 1000;
    localparam int S      = 10;
    localparam int M      = 4;
    localparam int LAT0   = G + 1;
    localparam int LAT_IT = 1 + S + G + 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       square_freq = 1'b0;
    logic [1:0] freq_up_down;
    logic [1:0] cal_glis;

    pitch_calib_ctrl_if #(.CNT_W(16)) ctl ();

    pitch_calib_ctrl #(
        .CNT_W         (16),
        .GATE_CYCLES   (G),
        .SETTLE_CYCLES (S),
        .MAX_ITER      (M)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ctl          (ctl),
        .square_freq  (square_freq),
        .freq_up_down (freq_up_down),
        .cal_glis     (cal_glis)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        int kind;   // 1 = done, 2 = fail
        int meas;
        int ups;
        int downs;
        int lat;
    } exp_t;

    exp_t sb[$];

    int ncyc = 0;
    int start_cyc = 0;
    int ups = 0;
    int downs = 0;
    int osc_n = 100;
    bit osc_en = 1'b0;
    bit track = 1'b0;

    initial forever @(posedge clk) ncyc++;

    // Rate model: exactly osc_n rising edges in any 1000 consecutive cycles.
    initial begin
        int acc;
        int hi;
        acc = 0;
        hi  = 0;
        forever begin
            @(negedge clk);
            if (!osc_en) begin
                hi = 0;
                square_freq = 1'b0;
            end else begin
                acc = acc + osc_n;
                if (acc >= 1000) begin
                    acc = acc - 1000;
                    hi  = 2;
                end else if (hi > 0) begin
                    hi = hi - 1;
                end
                square_freq = (hi > 0);
            end
        end
    end

    initial begin
        exp_t e;
        bit   prev_pulse;
        prev_pulse = 1'b0;
        forever begin
            @(negedge clk);
            if (freq_up_down == 2'b01) begin
                ups++;
                if (track) osc_n = osc_n + 5;
            end
            if (freq_up_down == 2'b10) begin
                downs++;
                if (track) osc_n = osc_n - 5;
            end
            if (freq_up_down == 2'b11) check_val("ud_illegal", freq_up_down, 0);
            if (ctl.done || ctl.fail) begin
                if (prev_pulse) check_val("pulse_width", 2, 1);
                if (sb.size() == 0) begin
                    check_val("unexpected_pulse", {ctl.done, ctl.fail}, 0);
                end else begin
                    e = sb.pop_front();
                    check_val("kind", ctl.done ? 1 : 2, e.kind);
                    check_val("meas_cnt", ctl.meas_cnt, e.meas);
                    check_val("ups", ups, e.ups);
                    check_val("downs", downs, e.downs);
                    check_val("latency", ncyc - start_cyc - 1, e.lat);
                    check_val("cal_glis_end", cal_glis, (e.kind == 1) ? 2 : 3);
                    check_val("busy_end", ctl.busy, 0);
                end
            end
            prev_pulse = ctl.done || ctl.fail;
        end
    end

    task automatic do_start(input int tgt, input int tl, input bit accepted);
        @(negedge clk);
        ctl.start      = 1'b1;
        ctl.target_cnt = tgt[15:0];
        ctl.tol        = tl[15:0];
        if (accepted) begin
            start_cyc = ncyc;
            ups   = 0;
            downs = 0;
        end
        @(negedge clk);
        ctl.start = 1'b0;
        if (accepted) begin
            check_val("busy_after_start", ctl.busy, 1);
            check_val("cal_glis_cal", cal_glis, 1);
        end
    endtask

    task automatic push_exp(input int kind, input int meas, input int u, input int d, input int lat);
        exp_t e;
        e.kind = kind; e.meas = meas; e.ups = u; e.downs = d; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit && sb.size() != 0; i++) @(negedge clk);
        check_val("drain", sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ud"},   freq_up_down, 0);
        check_val({tag, "_cg"},   cal_glis, 0);
        check_val({tag, "_busy"}, ctl.busy, 0);
        check_val({tag, "_done"}, ctl.done, 0);
        check_val({tag, "_fail"}, ctl.fail, 0);
        check_val({tag, "_meas"}, ctl.meas_cnt, 0);
    endtask

    initial begin
        ctl.start = 1'b0;
        ctl.abort = 1'b0;
        ctl.target_cnt = '0;
        ctl.tol = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;

        // Steady clk/10 oscillator, already on target
        osc_en = 1'b1; osc_n = 100; track = 1'b0;
        repeat (20) @(negedge clk);
        push_exp(1, 100, 0, 0, LAT0);
        do_start(100, 2, 1'b1);
        wait_drain(5000);

        // Two up steps from 90 to 100
        osc_n = 90; track = 1'b1;
        repeat (20) @(negedge clk);
        push_exp(1, 100, 2, 0, LAT0 + 2 * LAT_IT);
        do_start(100, 1, 1'b1);
        wait_drain(10000);

        // Unreachable target: four down steps then fail
        osc_n = 200; track = 1'b0;
        repeat (20) @(negedge clk);
        push_exp(2, 200, 0, M, LAT0 + M * LAT_IT);
        do_start(100, 0, 1'b1);
        wait_drain(15000);

        // Abort during the second settle, then restart with a new target
        osc_n = 90; track = 1'b1;
        repeat (20) @(negedge clk);
        do_start(100, 0, 1'b1);
        for (int i = 0; i < 5000 && ups < 2; i++) @(negedge clk);
        check_val("abort_reach_iter2", ups, 2);
        repeat (4) @(negedge clk);
        ctl.abort = 1'b1;
        @(negedge clk);
        ctl.abort = 1'b0;
        check_val("abort_cg", cal_glis, 0);
        check_val("abort_busy", ctl.busy, 0);
        check_val("abort_ud", freq_up_down, 0);
        repeat (1100) @(negedge clk);
        check_val("abort_idle_cg", cal_glis, 0);
        osc_n = 120; track = 1'b0;
        repeat (20) @(negedge clk);
        push_exp(1, 120, 0, 0, LAT0);
        do_start(120, 0, 1'b1);
        wait_drain(5000);

        // Async reset mid-measure, then a silent input with maximum tolerance
        osc_n = 100;
        do_start(100, 2, 1'b1);
        repeat (300) @(negedge clk);
        check_val("pre_reset_busy", ctl.busy, 1);
        check_val("pre_reset_meas", ctl.meas_cnt, 120);
        #2 reset_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        osc_en = 1'b0;
        repeat (10) @(negedge clk);
        push_exp(1, 0, 0, 0, LAT0);
        do_start(0, 65535, 1'b1);
        wait_drain(5000);

        // Abort from LOCKED, then start and abort together from IDLE
        @(negedge clk);
        ctl.abort = 1'b1;
        @(negedge clk);
        ctl.abort = 1'b0;
        check_val("lock_abort_cg", cal_glis, 0);
        ctl.start = 1'b1;
        ctl.abort = 1'b1;
        ctl.target_cnt = 16'd5;
        @(negedge clk);
        ctl.start = 1'b0;
        ctl.abort = 1'b0;
        check_val("start_abort_busy", ctl.busy, 0);
        check_val("start_abort_cg", cal_glis, 0);
        repeat (1100) @(negedge clk);
        check_val("start_abort_idle", ctl.busy, 0);

        // Start while busy must not relatch target or restart iterations
        osc_en = 1'b1; osc_n = 200; track = 1'b0;
        repeat (20) @(negedge clk);
        push_exp(2, 200, 0, M, LAT0 + M * LAT_IT);
        do_start(100, 0, 1'b1);
        repeat (2500) @(negedge clk);
        do_start(200, 0, 1'b0);
        wait_drain(15000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
